// File: rtl/fft_channel_scheduler.sv
// Round-robin arbiter that lends a single FFT engine to N_CHANNELS frame requesters,
// one transform in flight, returning each result to the channel that submitted it.
module fft_channel_scheduler #(
  parameter int BIT_WIDTH  = 32,
  parameter int N_SAMPLES  = 8,
  parameter int N_CHANNELS = 4,
  parameter int LAT_WIDTH  = 16,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic [N_CHANNELS-1:0][N_SAMPLES-1:0][BIT_WIDTH-1:0] req_msg,
  input  logic [N_CHANNELS-1:0]                             req_val,
  output logic [N_CHANNELS-1:0]                             req_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]               resp_msg,
  output logic [N_CHANNELS-1:0]                             resp_val,
  input  logic [N_CHANNELS-1:0]                             resp_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]               fft_send_msg,
  output logic                                              fft_send_val,
  input  logic                                              fft_send_rdy,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]               fft_recv_msg,
  input  logic                                              fft_recv_val,
  output logic                                              fft_recv_rdy,
  output logic [CW-1:0]                                     grant_id,
  output logic                                              busy,
  output logic [LAT_WIDTH-1:0]                              last_latency
);

  // state     | meaning
  // S_IDLE    | pick next requester round-robin from ptr
  // S_ISSUE   | offer latched frame to the FFT engine
  // S_WAIT    | count cycles until the FFT result arrives
  // S_DELIVER | hold result for the granted channel
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t                             state, state_next;
  logic [CW-1:0]                      ptr, ptr_next, winner;
  logic                               found;
  int                                 idx;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] frame_reg, result_reg;
  logic [LAT_WIDTH-1:0]               lat_cnt, lat_inc;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
      if (!found && req_val[idx]) begin
        found  = 1'b1;
        winner = CW'(idx);
      end
    end
  end

  assign lat_inc  = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;
  assign ptr_next = (int'(grant_id) == N_CHANNELS - 1) ? '0 : grant_id + 1'b1;

  assign fft_send_msg = frame_reg;
  assign resp_msg     = result_reg;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // req_rdy is gated by reset so that a live req_val cannot look accepted while held in reset
  always_comb begin
    state_next   = state;
    req_rdy      = '0;
    resp_val     = '0;
    fft_send_val = 1'b0;
    fft_recv_rdy = 1'b0;
    case (state)
      S_IDLE: begin
        if (found && reset) begin
          req_rdy[winner] = 1'b1;
          state_next      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fft_send_val = 1'b1;
        if (fft_send_rdy) state_next = S_WAIT;
      end
      S_WAIT: begin
        fft_recv_rdy = 1'b1;
        if (fft_recv_val) state_next = S_DELIVER;
      end
      S_DELIVER: begin
        resp_val[grant_id] = 1'b1;
        if (resp_rdy[grant_id]) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      grant_id     <= '0;
      last_latency <= '0;
      lat_cnt      <= '0;
      frame_reg    <= '0;
      result_reg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            frame_reg <= req_msg[winner];
            grant_id  <= winner;
          end
        end
        S_ISSUE: begin
          if (fft_send_rdy) lat_cnt <= '0;
        end
        S_WAIT: begin
          lat_cnt <= lat_inc;
          if (fft_recv_val) begin
            result_reg   <= fft_recv_msg;
            last_latency <= lat_inc;
          end
        end
        S_DELIVER: begin
          if (resp_rdy[grant_id]) ptr <= ptr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_channel_scheduler.sv
// Directed + randomized bench for fft_channel_scheduler; a 4-channel instance is checked
// against a round-robin reference model, a 3-channel instance with 2-bit latency covers wrap and saturation.
module tb_fft_channel_scheduler;
  localparam int BW = 32;
  localparam int NS = 8;
  localparam int NC = 4;
  localparam int LW = 16;

  typedef logic [NS-1:0][BW-1:0] frame_t;

  logic clk = 1'b0;
  logic reset;
  logic [NC-1:0][NS-1:0][BW-1:0] req_msg;
  logic [NC-1:0] req_val, req_rdy, resp_val, resp_rdy;
  frame_t resp_msg, fft_send_msg, fft_recv_msg;
  logic fft_send_val, fft_send_rdy, fft_recv_val, fft_recv_rdy;
  logic [1:0] grant_id;
  logic busy;
  logic [LW-1:0] last_latency;

  logic reset3;
  logic [2:0][NS-1:0][BW-1:0] req_msg3;
  logic [2:0] req_val3, req_rdy3, resp_val3, resp_rdy3;
  frame_t resp_msg3, fft_send_msg3, fft_recv_msg3;
  logic fft_send_val3, fft_send_rdy3, fft_recv_val3, fft_recv_rdy3;
  logic [1:0] grant_id3;
  logic busy3;
  logic [1:0] last_latency3;

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;
  int m_ptr = 0;

  fft_channel_scheduler #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .N_CHANNELS(NC), .LAT_WIDTH(LW)) u_dut (
    .clk(clk), .reset(reset),
    .req_msg(req_msg), .req_val(req_val), .req_rdy(req_rdy),
    .resp_msg(resp_msg), .resp_val(resp_val), .resp_rdy(resp_rdy),
    .fft_send_msg(fft_send_msg), .fft_send_val(fft_send_val), .fft_send_rdy(fft_send_rdy),
    .fft_recv_msg(fft_recv_msg), .fft_recv_val(fft_recv_val), .fft_recv_rdy(fft_recv_rdy),
    .grant_id(grant_id), .busy(busy), .last_latency(last_latency)
  );

  fft_channel_scheduler #(.BIT_WIDTH(BW), .N_SAMPLES(NS), .N_CHANNELS(3), .LAT_WIDTH(2)) u_dut3 (
    .clk(clk), .reset(reset3),
    .req_msg(req_msg3), .req_val(req_val3), .req_rdy(req_rdy3),
    .resp_msg(resp_msg3), .resp_val(resp_val3), .resp_rdy(resp_rdy3),
    .fft_send_msg(fft_send_msg3), .fft_send_val(fft_send_val3), .fft_send_rdy(fft_send_rdy3),
    .fft_recv_msg(fft_recv_msg3), .fft_recv_val(fft_recv_val3), .fft_recv_rdy(fft_recv_rdy3),
    .grant_id(grant_id3), .busy(busy3), .last_latency(last_latency3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic frame_t rnd_frame();
    frame_t f;
    for (int i = 0; i < NS; i++) f[i] = $urandom;
    return f;
  endfunction

  // Reference arbiter: first requester at or after the rotating pointer.
  function automatic int pick(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) begin
      int c = (m_ptr + i) % NC;
      if (v[c]) return c;
    end
    return 0;
  endfunction

  // Entered and left just after a rising edge with the DUT in IDLE.
  task automatic do_transform(input logic [NC-1:0] vals, input int s_stall, input int lat,
                              input int r_stall, input frame_t frame, input frame_t result,
                              input logic use_frame);
    int w;
    logic [NC-1:0] oh;
    frame_t exp_frame;
    w  = pick(vals);
    oh = 4'b0001 << w;
    for (int c = 0; c < NC; c++) req_msg[c] = rnd_frame();
    if (use_frame) req_msg[w] = frame;
    exp_frame = req_msg[w];
    req_val = vals;
    @(negedge clk);
    check("idle_req_rdy", 256'(req_rdy), 256'(oh));
    check("idle_busy", 256'(busy), 256'(1'b0));
    @(posedge clk); #1;
    fft_send_rdy = 1'b0;
    for (int k = 0; k < s_stall; k++) begin
      @(negedge clk);
      check("issue_stall_val", 256'(fft_send_val), 256'(1'b1));
      check("issue_stall_msg", 256'(fft_send_msg), 256'(exp_frame));
      check("issue_stall_req_rdy", 256'(req_rdy), 256'(0));
      @(posedge clk); #1;
    end
    fft_send_rdy = 1'b1;
    @(negedge clk);
    check("issue_msg", 256'(fft_send_msg), 256'(exp_frame));
    check("issue_grant", 256'(grant_id), 256'(w));
    check("issue_busy", 256'(busy), 256'(1'b1));
    @(posedge clk); #1;
    fft_send_rdy = 1'b0;
    for (int k = 0; k < lat - 1; k++) begin
      @(negedge clk);
      check("wait_recv_rdy", 256'(fft_recv_rdy), 256'(1'b1));
      check("wait_resp_val", 256'(resp_val), 256'(0));
      @(posedge clk); #1;
    end
    fft_recv_msg = result;
    fft_recv_val = 1'b1;
    @(negedge clk);
    check("wait_recv_rdy_last", 256'(fft_recv_rdy), 256'(1'b1));
    @(posedge clk); #1;
    fft_recv_val = 1'b0;
    fft_recv_msg = rnd_frame();
    req_val  = '1;
    resp_rdy = ~oh;
    for (int k = 0; k < r_stall; k++) begin
      @(negedge clk);
      check("deliver_stall_val", 256'(resp_val), 256'(oh));
      check("deliver_stall_msg", 256'(resp_msg), 256'(result));
      check("deliver_stall_req_rdy", 256'(req_rdy), 256'(0));
      @(posedge clk); #1;
    end
    resp_rdy = '1;
    @(negedge clk);
    check("deliver_val", 256'(resp_val), 256'(oh));
    check("deliver_msg", 256'(resp_msg), 256'(result));
    check("deliver_req_rdy", 256'(req_rdy), 256'(0));
    check("last_latency", 256'(last_latency), 256'(lat));
    @(posedge clk); #1;
    req_val  = '0;
    resp_rdy = '0;
    check("post_busy", 256'(busy), 256'(1'b0));
    m_ptr = (w + 1) % NC;
  endtask

  initial begin
    frame_t impulse, flat;
    int got3;
    logic [2:0] exp3;
    int ptr3;
    logic seen;

    reset = 1'b0;
    reset3 = 1'b0;
    req_msg = '0;
    req_val = '1;
    resp_rdy = '0;
    fft_send_rdy = 1'b0;
    fft_recv_val = 1'b0;
    fft_recv_msg = '0;
    for (int c = 0; c < 3; c++) req_msg3[c] = rnd_frame();
    req_val3 = 3'b111;
    resp_rdy3 = 3'b111;
    fft_send_rdy3 = 1'b1;
    fft_recv_val3 = 1'b1;
    fft_recv_msg3 = rnd_frame();

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_req_rdy", 256'(req_rdy), 256'(0));
      check("rst_resp_val", 256'(resp_val), 256'(0));
      check("rst_send_val", 256'(fft_send_val), 256'(1'b0));
      check("rst_recv_rdy", 256'(fft_recv_rdy), 256'(1'b0));
      check("rst_busy", 256'(busy), 256'(1'b0));
      check("rst_last_latency", 256'(last_latency), 256'(0));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    req_val = '0;

    do_transform(4'hF, 0, 1, 0, rnd_frame(), rnd_frame(), 1'b0);

    impulse = '0;
    impulse[0] = 32'h0001_0000;
    for (int i = 0; i < NS; i++) flat[i] = 32'h0001_0000;
    do_transform(4'b0100, 0, 3, 0, impulse, flat, 1'b1);

    for (int k = 0; k < 6; k++) do_transform(4'hF, 0, 2, 0, rnd_frame(), rnd_frame(), 1'b0);

    do_transform(4'($urandom_range(1, 15)), 4, 5, 0, rnd_frame(), rnd_frame(), 1'b0);
    do_transform(4'b0010, 0, 2, 5, rnd_frame(), rnd_frame(), 1'b0);

    for (int k = 0; k < 10; k++)
      do_transform(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(1, 6),
                   $urandom_range(0, 3), rnd_frame(), rnd_frame(), 1'b0);

    req_val = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("idle_none_req_rdy", 256'(req_rdy), 256'(0));
      check("idle_none_busy", 256'(busy), 256'(1'b0));
    end
    @(posedge clk); #1;

    reset3 = 1'b1;
    got3 = 0;
    ptr3 = 0;
    for (int cyc = 0; cyc < 40 && got3 < 6; cyc++) begin
      @(negedge clk);
      if (|req_rdy3) begin
        exp3 = 3'b001 << ptr3;
        check("rr3_grant", 256'(req_rdy3), 256'(exp3));
        ptr3 = (ptr3 + 1) % 3;
        got3++;
      end
    end
    check("rr3_count", 256'(got3), 256'(6));
    check("rr3_latency", 256'(last_latency3), 256'(1));
    fft_recv_val3 = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      if (fft_recv_rdy3) seen = 1'b1;
    end
    check("sat_reach_wait", 256'(seen), 256'(1'b1));
    repeat (5) @(negedge clk);
    fft_recv_val3 = 1'b1;
    @(posedge clk); #1;
    check("sat_last_latency", 256'(last_latency3), 256'(2'd3));
    reset3 = 1'b0;

    @(posedge clk); #1;
    req_val = 4'b0100;
    @(posedge clk); #1;
    req_val = '0;
    fft_send_rdy = 1'b1;
    @(posedge clk); #1;
    fft_send_rdy = 1'b0;
    @(negedge clk);
    check("rstw_in_wait", 256'(fft_recv_rdy), 256'(1'b1));
    reset = 1'b0;
    #1;
    check("rstw_recv_rdy", 256'(fft_recv_rdy), 256'(1'b0));
    check("rstw_busy", 256'(busy), 256'(1'b0));
    check("rstw_grant", 256'(grant_id), 256'(0));
    check("rstw_last_latency", 256'(last_latency), 256'(0));
    check("rstw_frame", 256'(fft_send_msg), 256'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    fft_recv_msg = rnd_frame();
    fft_recv_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstw_post_recv_rdy", 256'(fft_recv_rdy), 256'(1'b0));
      check("rstw_post_resp_val", 256'(resp_val), 256'(0));
      check("rstw_post_busy", 256'(busy), 256'(1'b0));
    end
    fft_recv_val = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
